rx_deframer: RTL and testbench

RX_DEFRAMER -- requirements
Module: rx_deframer

---
 rtl/rx_deframer_pkg.sv | 15 +
 rtl/rx_nibble_packer.sv | 43 ++++
 rtl/rx_deframer.sv | 151 +++++++++++++++
 tb/tb_rx_deframer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_deframer_pkg.sv
// Shared types and default framing constants for the receive deframer.
package rx_deframer_pkg;

    typedef enum logic [1:0] {
        HUNT,
        SYNC,
        PHR,
        PAYLOAD
    } deframerState_e;

    localparam int         PRE_MIN_DEFAULT = 8;
    localparam logic [7:0] SFD_DEFAULT     = 8'hA7;
    localparam int         MAX_LEN_DEFAULT = 127;

endpackage

// File: rtl/rx_nibble_packer.sv
// Packs serial bits (LSB first) into nibbles and counts completed nibbles.
// The nibble value and ready flag are presented combinationally on the
// strobe carrying the 4th bit so the parent can register them directly.
module rx_nibble_packer (
    input  logic       clk,
    input  logic       rstN,
    input  logic       clear,
    input  logic       bitValid,
    input  logic       bitIn,
    output logic       nibbleReady,
    output logic [3:0] nibbleValue,
    output logic [7:0] nibbleCount
);

    logic [2:0] shiftReg;
    logic [1:0] bitCnt;

    // The 4th bit completes the nibble in place; earlier bits sit in shiftReg.
    always_comb begin
        nibbleReady = bitValid && (bitCnt == 2'd3);
        nibbleValue = {bitIn, shiftReg};
    end

    // Shift bits in at the top, moving right, and count finished nibbles.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            shiftReg    <= '0;
            bitCnt      <= '0;
            nibbleCount <= '0;
        end else if (clear) begin
            shiftReg    <= '0;
            bitCnt      <= '0;
            nibbleCount <= '0;
        end else if (bitValid) begin
            shiftReg <= {bitIn, shiftReg[2:1]};
            bitCnt   <= bitCnt + 2'd1;
            if (bitCnt == 2'd3) begin
                nibbleCount <= nibbleCount + 8'd1;
            end
        end
    end

endmodule

// File: rtl/rx_deframer.sv
// Serial receive deframer: preamble hunt, SFD sync, PHR length capture and
// payload nibble emission towards the output FIFO.
module rx_deframer
    import rx_deframer_pkg::*;
#(
    parameter int         PRE_MIN = PRE_MIN_DEFAULT,
    parameter logic [7:0] SFD     = SFD_DEFAULT,
    parameter int         MAX_LEN = MAX_LEN_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_flag,
    input  logic       i_data,
    input  logic       i_full,
    output logic       o_we,
    output logic [3:0] o_data,
    output logic       o_sfd_found,
    output logic [6:0] o_len,
    output logic       o_frame_done,
    output logic       o_frame_err
);

    localparam logic [7:0] PRE_MIN_W = 8'(PRE_MIN);
    localparam logic [7:0] MAX_LEN_W = 8'(MAX_LEN);

    deframerState_e state;
    logic [7:0]     zeroCnt;
    logic [7:0]     zeroNext;
    logic [7:0]     shiftReg;
    logic [7:0]     srNext;
    logic [2:0]     bitCnt;
    logic           seenOne;
    logic           countedBit;
    logic           overflow;
    logic           lenBad;
    logic           lastNibble;
    logic           payloadBit;
    logic           nibbleReady;
    logic [3:0]     nibbleValue;
    logic [7:0]     nibbleCount;

    // Next-value helpers: saturating zero run, shifted SFD/PHR register, length checks.
    always_comb begin
        zeroNext   = i_data ? 8'd0 : ((zeroCnt == PRE_MIN_W) ? zeroCnt : zeroCnt + 8'd1);
        srNext     = {i_data, shiftReg[7:1]};
        countedBit = i_data | seenOne;
        lenBad     = (srNext[6:0] == 7'd0) || ({1'b0, srNext[6:0]} > MAX_LEN_W);
        lastNibble = (nibbleCount == ({o_len, 1'b0} - 8'd1));
        payloadBit = i_flag && (state == PAYLOAD);
    end

    rx_nibble_packer uPacker (
        .clk         (i_clk),
        .rstN        (i_rst_n),
        .clear       (state != PAYLOAD),
        .bitValid    (payloadBit),
        .bitIn       (i_data),
        .nibbleReady (nibbleReady),
        .nibbleValue (nibbleValue),
        .nibbleCount (nibbleCount)
    );

    // Frame FSM with registered strobes; everything advances only on i_flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= HUNT;
            zeroCnt      <= '0;
            shiftReg     <= '0;
            bitCnt       <= '0;
            seenOne      <= 1'b0;
            overflow     <= 1'b0;
            o_we         <= 1'b0;
            o_data       <= '0;
            o_sfd_found  <= 1'b0;
            o_len        <= '0;
            o_frame_done <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            o_we         <= 1'b0;
            o_sfd_found  <= 1'b0;
            o_frame_done <= 1'b0;
            o_frame_err  <= 1'b0;
            if (i_flag) begin
                case (state)
                    HUNT: begin
                        zeroCnt <= zeroNext;
                        if (zeroNext == PRE_MIN_W) begin
                            state    <= SYNC;
                            shiftReg <= '0;
                            bitCnt   <= '0;
                            seenOne  <= 1'b0;
                        end
                    end
                    SYNC: begin
                        // Leading zeros are still preamble; the 8-bit window opens at the first 1.
                        shiftReg <= srNext;
                        if (countedBit) begin
                            seenOne <= 1'b1;
                            bitCnt  <= bitCnt + 3'd1;
                        end
                        if (srNext == SFD) begin
                            state       <= PHR;
                            bitCnt      <= '0;
                            o_sfd_found <= 1'b1;
                        end else if (countedBit && (bitCnt == 3'd7)) begin
                            state   <= HUNT;
                            zeroCnt <= '0;
                        end
                    end
                    PHR: begin
                        shiftReg <= srNext;
                        bitCnt   <= bitCnt + 3'd1;
                        if (bitCnt == 3'd7) begin
                            o_len <= srNext[6:0];
                            if (lenBad) begin
                                state       <= HUNT;
                                zeroCnt     <= '0;
                                o_frame_err <= 1'b1;
                            end else begin
                                state <= PAYLOAD;
                            end
                        end
                    end
                    PAYLOAD: begin
                        if (nibbleReady) begin
                            if (!i_full) begin
                                o_we   <= 1'b1;
                                o_data <= nibbleValue;
                            end else begin
                                overflow <= 1'b1;
                            end
                            // A drop on the final nibble itself must still flag the frame.
                            if (lastNibble) begin
                                state    <= HUNT;
                                zeroCnt  <= '0;
                                overflow <= 1'b0;
                                if (overflow || i_full) begin
                                    o_frame_err <= 1'b1;
                                end else begin
                                    o_frame_done <= 1'b1;
                                end
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_deframer.sv
// Directed testbench for rx_deframer.
`timescale 1ns/1ps
module tb_rx_deframer;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       flag = 1'b0;
    logic       dataBit = 1'b0;
    logic       full = 1'b0;
    logic       we;
    logic [3:0] outData;
    logic       sfdFound;
    logic [6:0] len;
    logic       frameDone;
    logic       frameErr;

    int passCnt = 0;
    int totalCnt = 0;

    int       weCnt = 0;
    logic [3:0] wdata [0:15];
    int       sfdCnt = 0;
    int       doneCnt = 0;
    int       errCnt = 0;
    int       doneWe = 0;
    int       errWe = 0;

    rx_deframer dut (
        .i_clk        (clk),
        .i_rst_n      (rstN),
        .i_flag       (flag),
        .i_data       (dataBit),
        .i_full       (full),
        .o_we         (we),
        .o_data       (outData),
        .o_sfd_found  (sfdFound),
        .o_len        (len),
        .o_frame_done (frameDone),
        .o_frame_err  (frameErr)
    );

    always #5 clk = ~clk;

    // Output monitor: every pulse is seen on exactly one falling edge.
    always @(negedge clk) begin
        if (we) begin
            if (weCnt < 16) wdata[weCnt] = outData;
            weCnt++;
        end
        if (sfdFound) sfdCnt++;
        if (frameDone) doneCnt++;
        if (frameErr) errCnt++;
        if (frameDone && we) doneWe++;
        if (frameErr && we) errWe++;
    end

    task automatic clearMon();
        @(negedge clk);
        #1;
        weCnt = 0; sfdCnt = 0; doneCnt = 0; errCnt = 0; doneWe = 0; errWe = 0;
        for (int i = 0; i < 16; i++) wdata[i] = 4'h0;
    endtask

    task automatic sendBit(input logic b, input logic f);
        @(negedge clk);
        flag = 1'b1; dataBit = b; full = f;
        @(negedge clk);
        flag = 1'b0; full = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] v, input logic [1:0] fullNib);
        for (int i = 0; i < 8; i++)
            sendBit(v[i], ((i == 3) && fullNib[0]) || ((i == 7) && fullNib[1]));
    endtask

    task automatic sendZeros(input int n);
        for (int i = 0; i < n; i++) sendBit(1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sendHeader(input logic [7:0] phr);
        sendBit(1'b1, 1'b0);
        sendZeros(32);
        sendByte(8'hA7, 2'b00);
        sendByte(phr, 2'b00);
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        totalCnt++;
        if ({we, outData, sfdFound, len, frameDone, frameErr} !== 15'd0)
            $display("FAIL reset_outputs got=%h want=0", {we, outData, sfdFound, len, frameDone, frameErr});
        else passCnt++;
        @(negedge clk);
        rstN = 1'b1;
        idle(2);
    endtask

    task automatic test_good_frame();
        logic [3:0] exp [0:3];
        exp[0] = 4'hC; exp[1] = 4'h3; exp[2] = 4'hA; exp[3] = 4'h5;
        clearMon();
        sendHeader(8'h02);
        sendByte(8'h3C, 2'b00);
        sendByte(8'h5A, 2'b00);
        idle(4);
        totalCnt++;
        if (sfdCnt !== 1) $display("FAIL good_sfd got=%0d want=1", sfdCnt); else passCnt++;
        totalCnt++;
        if (len !== 7'd2) $display("FAIL good_len got=%0d want=2", len); else passCnt++;
        totalCnt++;
        if (weCnt !== 4) $display("FAIL good_we_count got=%0d want=4", weCnt); else passCnt++;
        for (int i = 0; i < 4; i++) begin
            totalCnt++;
            if (wdata[i] !== exp[i]) $display("FAIL good_nibble%0d got=%h want=%h", i, wdata[i], exp[i]);
            else passCnt++;
        end
        totalCnt++;
        if (doneCnt !== 1 || doneWe !== 1) $display("FAIL good_done got=%0d/%0d want=1/1", doneCnt, doneWe); else passCnt++;
        totalCnt++;
        if (errCnt !== 0) $display("FAIL good_err got=%0d want=0", errCnt); else passCnt++;
        totalCnt++;
        if (outData !== 4'h5 || len !== 7'd2) $display("FAIL good_hold got=%h/%0d want=5/2", outData, len); else passCnt++;
    endtask

    task automatic test_zero_len();
        clearMon();
        sendHeader(8'h00);
        idle(4);
        totalCnt++;
        if (sfdCnt !== 1 || errCnt !== 1) $display("FAIL zlen_err got=%0d/%0d want=1/1", sfdCnt, errCnt); else passCnt++;
        totalCnt++;
        if (weCnt !== 0 || doneCnt !== 0) $display("FAIL zlen_no_we got=%0d/%0d want=0/0", weCnt, doneCnt); else passCnt++;
        clearMon();
        sendHeader(8'h01);
        sendByte(8'h96, 2'b00);
        idle(4);
        totalCnt++;
        if (weCnt !== 2 || wdata[0] !== 4'h6 || wdata[1] !== 4'h9)
            $display("FAIL zlen_next_data got=%0d:%h%h want=2:69", weCnt, wdata[0], wdata[1]);
        else passCnt++;
        totalCnt++;
        if (doneCnt !== 1 || errCnt !== 0) $display("FAIL zlen_next_done got=%0d/%0d want=1/0", doneCnt, errCnt); else passCnt++;
    endtask

    task automatic test_short_preamble();
        clearMon();
        sendBit(1'b1, 1'b0);
        sendZeros(4);
        sendByte(8'hA7, 2'b00);
        sendBit(1'b1, 1'b0);
        sendZeros(7);
        sendByte(8'hA7, 2'b00);
        sendBit(1'b1, 1'b0);
        idle(4);
        totalCnt++;
        if (sfdCnt !== 0) $display("FAIL short_pre_sfd got=%0d want=0", sfdCnt); else passCnt++;
    endtask

    task automatic test_bad_sfd();
        clearMon();
        sendBit(1'b1, 1'b0);
        sendZeros(8);
        sendByte(8'hA6, 2'b00);
        sendBit(1'b0, 1'b0);
        sendZeros(4);
        sendByte(8'hA7, 2'b00);
        sendBit(1'b1, 1'b0);
        idle(4);
        totalCnt++;
        if (sfdCnt !== 0) $display("FAIL bad_sfd got=%0d want=0", sfdCnt); else passCnt++;
    endtask

    task automatic test_min_preamble();
        clearMon();
        sendBit(1'b1, 1'b0);
        sendZeros(8);
        sendByte(8'hA7, 2'b00);
        sendByte(8'h01, 2'b00);
        sendByte(8'h21, 2'b00);
        idle(4);
        totalCnt++;
        if (sfdCnt !== 1 || weCnt !== 2 || wdata[0] !== 4'h1 || wdata[1] !== 4'h2)
            $display("FAIL min_pre got=%0d/%0d:%h%h want=1/2:12", sfdCnt, weCnt, wdata[0], wdata[1]);
        else passCnt++;
        totalCnt++;
        if (doneCnt !== 1) $display("FAIL min_pre_done got=%0d want=1", doneCnt); else passCnt++;
    endtask

    task automatic test_overflow();
        clearMon();
        sendHeader(8'h02);
        sendByte(8'h3C, 2'b10);
        sendByte(8'h5A, 2'b00);
        idle(4);
        totalCnt++;
        if (weCnt !== 3 || wdata[0] !== 4'hC || wdata[1] !== 4'hA || wdata[2] !== 4'h5)
            $display("FAIL ovf_data got=%0d:%h%h%h want=3:CA5", weCnt, wdata[0], wdata[1], wdata[2]);
        else passCnt++;
        totalCnt++;
        if (errCnt !== 1 || errWe !== 1 || doneCnt !== 0)
            $display("FAIL ovf_err got=%0d/%0d/%0d want=1/1/0", errCnt, errWe, doneCnt);
        else passCnt++;
        clearMon();
        sendHeader(8'h01);
        sendByte(8'h96, 2'b00);
        idle(4);
        totalCnt++;
        if (doneCnt !== 1 || errCnt !== 0) $display("FAIL ovf_cleared got=%0d/%0d want=1/0", doneCnt, errCnt); else passCnt++;
    endtask

    task automatic test_reset_mid();
        clearMon();
        sendHeader(8'h02);
        sendByte(8'h3C, 2'b00);
        sendBit(1'b0, 1'b0);
        sendBit(1'b1, 1'b0);
        totalCnt++;
        if (outData !== 4'h3 || len !== 7'd2) $display("FAIL rstmid_pre got=%h/%0d want=3/2", outData, len); else passCnt++;
        #2;
        rstN = 1'b0;
        #1;
        totalCnt++;
        if ({we, outData, sfdFound, len, frameDone, frameErr} !== 15'd0)
            $display("FAIL rstmid_outputs got=%h want=0", {we, outData, sfdFound, len, frameDone, frameErr});
        else passCnt++;
        idle(2);
        #3;
        rstN = 1'b1;
        idle(2);
        totalCnt++;
        if (errCnt !== 0 || doneCnt !== 0) $display("FAIL rstmid_no_err got=%0d/%0d want=0/0", errCnt, doneCnt); else passCnt++;
        clearMon();
        sendHeader(8'h02);
        sendByte(8'h3C, 2'b00);
        sendByte(8'h5A, 2'b00);
        idle(4);
        totalCnt++;
        if (weCnt !== 4 || wdata[0] !== 4'hC || wdata[1] !== 4'h3 || wdata[2] !== 4'hA || wdata[3] !== 4'h5)
            $display("FAIL rstmid_next got=%0d:%h%h%h%h want=4:C3A5", weCnt, wdata[0], wdata[1], wdata[2], wdata[3]);
        else passCnt++;
        totalCnt++;
        if (doneCnt !== 1 || errCnt !== 0) $display("FAIL rstmid_next_done got=%0d/%0d want=1/0", doneCnt, errCnt); else passCnt++;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_zero_len();
        test_short_preamble();
        test_bad_sfd();
        test_min_preamble();
        test_overflow();
        test_reset_mid();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
